// File: rtl/adc_sample_avg_pkg.sv
// ============================================================================
// adc_sample_avg_pkg : shared state encoding and ADC width for the fan path
// Rev 1.0
// ============================================================================
`default_nettype none

package adc_sample_avg_pkg;

    localparam int DEF_ADC_BITWIDTH = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACC   = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/adc_sample_avg_sync_rise_det.sv
// ============================================================================
// adc_sample_avg_sync_rise_det : multi-flop synchroniser plus rising-edge detect
// Rev 1.0
// ============================================================================
`default_nettype none

module adc_sample_avg_sync_rise_det #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic              last_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            last_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o = sync_q[STAGES-1] & ~last_q;

endmodule

`default_nettype wire

// File: rtl/adc_sample_avg.sv
// ============================================================================
// adc_sample_avg : paces ADC conversions, captures results, box-car averages
// Rev 1.0
// ============================================================================
`default_nettype none

module adc_sample_avg
    import adc_sample_avg_pkg::*;
#(
    parameter int ADC_BITWIDTH = DEF_ADC_BITWIDTH,
    parameter int AVG_LOG2     = 2,
    parameter int CONV_DIV     = 100000,
    parameter int TIMEOUT      = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [ADC_BITWIDTH-1:0] adc_data_i,
    input  logic                    adc_drdy_i,
    output logic                    adc_start_o,
    output logic [ADC_BITWIDTH-1:0] adc_value_o,
    output logic                    data_valid_strb_o,
    output logic                    adc_timeout_o
);

    localparam int PACE_W = (CONV_DIV > 1) ? $clog2(CONV_DIV) : 1;
    localparam int TO_W   = $clog2(TIMEOUT + 1);
    localparam int ACC_W  = ADC_BITWIDTH + AVG_LOG2;
    localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [PACE_W-1:0] PACE_LAST = PACE_W'(CONV_DIV - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

    state_t                  state;
    state_t                  state_nx;
    logic [PACE_W-1:0]       pace_cnt;
    logic                    tick;
    logic                    pending;
    logic [TO_W-1:0]         to_cnt;
    logic [ADC_BITWIDTH-1:0] sample;
    logic [ACC_W-1:0]        acc;
    logic [ACC_W-1:0]        acc_sum;
    logic [CNT_W-1:0]        cnt;
    logic                    drdy_rise;

    logic take_pending;
    logic capture;
    logic to_expire;
    logic acc_step;

    adc_sample_avg_sync_rise_det #(
        .STAGES (2)
    ) u_drdy_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (adc_drdy_i),
        .rise_o  (drdy_rise)
    );

    // Conversion pacing: one-deep pending flag absorbs ticks while busy.
    assign tick = (pace_cnt == PACE_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pace_cnt <= '0;
            pending  <= 1'b0;
        end else begin
            pace_cnt <= tick ? '0 : pace_cnt + 1'b1;
            pending  <= tick | (pending & ~take_pending);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (pending) state_nx = ST_START;
            ST_START: state_nx = ST_WAIT;
            ST_WAIT: begin
                if (drdy_rise) begin
                    state_nx = ST_ACC;
                end else if (to_cnt == TO_LAST) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_ACC:   state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        adc_start_o  = (state == ST_START);
        take_pending = (state == ST_IDLE) && pending;
        capture      = (state == ST_WAIT) && drdy_rise;
        to_expire    = (state == ST_WAIT) && !drdy_rise && (to_cnt == TO_LAST);
        acc_step     = (state == ST_ACC);
    end

    assign acc_sum = acc + ACC_W'(sample);

    // Accumulator is wide enough for 2^AVG_LOG2 full-scale samples.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            to_cnt            <= '0;
            sample            <= '0;
            acc               <= '0;
            cnt               <= '0;
            adc_value_o       <= '0;
            data_valid_strb_o <= 1'b0;
            adc_timeout_o     <= 1'b0;
        end else begin
            data_valid_strb_o <= 1'b0;
            if (adc_start_o) begin
                to_cnt <= '0;
            end else if (state == ST_WAIT && !drdy_rise) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (capture) begin
                sample <= adc_data_i;
            end
            if (to_expire) begin
                adc_timeout_o <= 1'b1;
            end
            if (acc_step) begin
                adc_timeout_o <= 1'b0;
                if (cnt == CNT_LAST) begin
                    adc_value_o       <= ADC_BITWIDTH'(acc_sum >> AVG_LOG2);
                    data_valid_strb_o <= 1'b1;
                    acc               <= '0;
                    cnt               <= '0;
                end else begin
                    acc <= acc_sum;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire
